// File: rtl/mult_fx_pkg.sv
// Shared types, limits and helpers for the pipelined fixed-point multiplier.
package mult_fx_pkg;

    localparam int unsigned LAT_MIN = 2;
    localparam int unsigned LAT_MAX = 6;
    // Widest intermediate value handled by the helpers below.
    localparam int unsigned MAX_W   = 64;

    // Which way a value left the output range, if at all.
    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_HI   = 2'd1,
        SAT_LO   = 2'd2
    } sat_kind_e;

    function automatic int unsigned P_W_f(input int unsigned a_w, input int unsigned b_w);
        return a_w + b_w;
    endfunction

    // Classify v against the range of a width-bit result.
    // v must already be sign-extended to MAX_W when is_signed is set.
    function automatic sat_kind_e sat_clamp(input logic [MAX_W-1:0] v,
                                            input int unsigned       width,
                                            input bit                is_signed);
        logic [MAX_W-1:0] hi;
        sat_kind_e        k;
        k = SAT_NONE;
        if (is_signed) begin
            hi = (MAX_W'(1) << (width - 1)) - MAX_W'(1);
            if ($signed(v) > $signed(hi)) begin
                k = SAT_HI;
            end else if ($signed(v) < $signed(~hi)) begin
                k = SAT_LO;
            end
        end else begin
            hi = (MAX_W'(1) << width) - MAX_W'(1);
            if (v > hi) begin
                k = SAT_HI;
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/mult_fx_pipe_if.sv
// Operand and result stream of mult_fx_pipe, both valid/ready handshaked.
interface mult_fx_pipe_if #(
    parameter int unsigned A_W   = 20,
    parameter int unsigned B_W   = 8,
    parameter int unsigned OUT_W = 28
);
    logic             i_valid;
    logic             i_ready;
    logic [A_W-1:0]   i_a;
    logic [B_W-1:0]   i_b;
    logic             o_valid;
    logic             o_ready;
    logic [OUT_W-1:0] o_p;
    logic             o_sat;

    modport master (
        output i_valid, i_a, i_b, o_ready,
        input  i_ready, o_valid, o_p, o_sat
    );

    modport slave (
        input  i_valid, i_a, i_b, o_ready,
        output i_ready, o_valid, o_p, o_sat
    );
endinterface

// File: rtl/mult_fx_stage.sv
// One pipeline register: valid bit plus data that only captures real beats.
module mult_fx_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_adv,
    input  logic         i_valid,
    input  logic [W-1:0] i_d,
    output logic         o_valid,
    output logic [W-1:0] o_d
);
    logic         r_valid;
    logic [W-1:0] r_d;

    // Valid bit: flushed by clear, otherwise follows upstream whenever the pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_adv) begin
            r_valid <= i_valid;
        end
    end

    // Data: loads only for a valid beat so bubbles do not toggle the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d <= '0;
        end else if (i_adv && i_valid && !i_clr) begin
            r_d <= i_d;
        end
    end

    assign o_valid = r_valid;
    assign o_d     = r_d;
endmodule

// File: rtl/mult_fx_pipe.sv
// Pipelined fixed-point multiplier with rounding shift, saturation and stream handshake.
module mult_fx_pipe
    import mult_fx_pkg::*;
#(
    parameter int unsigned A_W        = 20,
    parameter int unsigned B_W        = 8,
    parameter int unsigned A_SIGNED   = 0,
    parameter int unsigned B_SIGNED   = 0,
    parameter int unsigned LAT        = 3,
    parameter int unsigned FRAC_SHIFT = 0,
    parameter int unsigned ROUND      = 1,
    parameter int unsigned OUT_W      = 28,
    parameter int unsigned SAT        = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    mult_fx_pipe_if.slave bus
);
    localparam int unsigned P_W = P_W_f(A_W, B_W);
    localparam int unsigned D_W = P_W + 1;
    localparam bit          SGN = (A_SIGNED != 0) || (B_SIGNED != 0);
    // Half an LSB of the shifted result; zero when nothing is shifted out.
    localparam logic [D_W-1:0]   RND_K = (ROUND != 0) ? ((D_W'(1) << FRAC_SHIFT) >> 1) : '0;
    localparam logic [OUT_W-1:0] MAX_V = SGN ? OUT_W'((MAX_W'(1) << (OUT_W - 1)) - MAX_W'(1)) : '1;
    localparam logic [OUT_W-1:0] MIN_V = SGN ? ~MAX_V : '0;

    if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_bad_lat
        $error("mult_fx_pipe: LAT must lie within 2..6");
    end
    if (OUT_W < 1 || OUT_W > P_W) begin : g_bad_out_w
        $error("mult_fx_pipe: OUT_W must lie within 1..A_W+B_W");
    end
    if (FRAC_SHIFT >= P_W) begin : g_bad_shift
        $error("mult_fx_pipe: FRAC_SHIFT must be below A_W+B_W");
    end
    if (D_W > MAX_W) begin : g_bad_width
        $error("mult_fx_pipe: A_W+B_W too wide for the rounding datapath");
    end

    logic               w_adv;
    logic               w_acc;
    logic [LAT-1:0]     w_vq;
    logic [A_W+B_W-1:0] w_ops;
    logic [P_W-1:0]     w_a_ext;
    logic [P_W-1:0]     w_b_ext;
    logic [P_W-1:0]     w_prod;
    logic [P_W-1:0]     w_pq [LAT-1];
    logic [D_W-1:0]     w_rext;
    logic [D_W-1:0]     w_sum;
    logic [D_W-1:0]     w_shf;
    logic [MAX_W-1:0]   w_v64;
    sat_kind_e          w_kind;
    logic [OUT_W:0]     w_fin;
    logic [OUT_W:0]     w_out;

    // Whole pipe moves as one, like a DSP clock enable.
    assign w_adv       = ~w_vq[LAT-1] | bus.o_ready;
    assign bus.i_ready = w_adv & ~i_clr;
    assign w_acc       = bus.i_valid & w_adv & ~i_clr;

    // Extend both operands to the product width; the low P_W bits of the product are then
    // exact for any mix of signed and unsigned operands.
    always_comb begin
        w_a_ext = (A_SIGNED != 0) ? P_W'($signed(w_ops[A_W+B_W-1:B_W])) : P_W'(w_ops[A_W+B_W-1:B_W]);
        w_b_ext = (B_SIGNED != 0) ? P_W'($signed(w_ops[B_W-1:0]))       : P_W'(w_ops[B_W-1:0]);
        w_prod  = w_a_ext * w_b_ext;
    end

    assign w_pq[0] = w_prod;

    // Round, shift and saturate the product leaving the last middle stage.
    always_comb begin
        w_rext = SGN ? D_W'($signed(w_pq[LAT-2])) : D_W'(w_pq[LAT-2]);
        w_sum  = w_rext + RND_K;
        w_shf  = SGN ? D_W'($signed(w_sum) >>> FRAC_SHIFT) : (w_sum >> FRAC_SHIFT);
        w_v64  = SGN ? MAX_W'($signed(w_shf)) : MAX_W'(w_shf);
        w_kind = sat_clamp(w_v64, OUT_W, SGN);
        w_fin  = {1'b0, w_shf[OUT_W-1:0]};
        if (SAT != 0) begin
            case (w_kind)
                SAT_HI:  w_fin = {1'b1, MAX_V};
                SAT_LO:  w_fin = {1'b1, MIN_V};
                default: w_fin = {1'b0, w_shf[OUT_W-1:0]};
            endcase
        end
    end

    mult_fx_stage #(.W(A_W + B_W)) u_stage_in (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (i_clr),
        .i_adv   (w_adv),
        .i_valid (w_acc),
        .i_d     ({bus.i_a, bus.i_b}),
        .o_valid (w_vq[0]),
        .o_d     (w_ops)
    );

    for (genvar k = 1; k + 2 <= LAT; k++) begin : g_mid
        mult_fx_stage #(.W(P_W)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_clr   (i_clr),
            .i_adv   (w_adv),
            .i_valid (w_vq[k-1]),
            .i_d     (w_pq[k-1]),
            .o_valid (w_vq[k]),
            .o_d     (w_pq[k])
        );
    end

    mult_fx_stage #(.W(OUT_W + 1)) u_stage_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (i_clr),
        .i_adv   (w_adv),
        .i_valid (w_vq[LAT-2]),
        .i_d     (w_fin),
        .o_valid (w_vq[LAT-1]),
        .o_d     (w_out)
    );

    assign bus.o_valid = w_vq[LAT-1];
    assign bus.o_p     = w_out[OUT_W-1:0];
    assign bus.o_sat   = w_out[OUT_W];
endmodule

// File: tb/tb_mult_fx_pipe.sv
// Directed bench for mult_fx_pipe across several parameter sets.
module tb_mult_fx_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    mult_fx_pipe_if #(.A_W(20), .B_W(8), .OUT_W(28)) if0 ();
    mult_fx_pipe_if #(.A_W(20), .B_W(8), .OUT_W(28)) if1 ();
    mult_fx_pipe_if #(.A_W(20), .B_W(8), .OUT_W(20)) if2 ();
    mult_fx_pipe_if #(.A_W(20), .B_W(8), .OUT_W(16)) if3 ();
    mult_fx_pipe_if #(.A_W(20), .B_W(8), .OUT_W(16)) if4 ();
    mult_fx_pipe_if #(.A_W(20), .B_W(8), .OUT_W(28)) if5 ();

    mult_fx_pipe #(.LAT(3)) u0 (.clk(clk), .rst_n(rst_n), .i_clr(clr), .bus(if0));
    mult_fx_pipe #(.A_SIGNED(1), .B_SIGNED(1)) u1 (.clk(clk), .rst_n(rst_n), .i_clr(clr), .bus(if1));
    mult_fx_pipe #(.FRAC_SHIFT(8), .ROUND(1), .OUT_W(20)) u2 (.clk(clk), .rst_n(rst_n), .i_clr(clr), .bus(if2));
    mult_fx_pipe #(.OUT_W(16), .SAT(1)) u3 (.clk(clk), .rst_n(rst_n), .i_clr(clr), .bus(if3));
    mult_fx_pipe #(.OUT_W(16), .SAT(0)) u4 (.clk(clk), .rst_n(rst_n), .i_clr(clr), .bus(if4));
    mult_fx_pipe #(.LAT(2)) u5 (.clk(clk), .rst_n(rst_n), .i_clr(clr), .bus(if5));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 2ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One beat on u0 with o_ready high: output must appear exactly 3 edges after acceptance.
    task automatic beat0(input string tag, input logic [19:0] a, input logic [7:0] b,
                         input logic [27:0] exp);
        if0.i_a     = a;
        if0.i_b     = b;
        if0.i_valid = 1'b1;
        #1;
        chk({tag, "_ready"}, 64'(if0.i_ready), 64'd1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            if0.i_valid = 1'b0;
            chk({tag, "_valid"}, 64'(if0.o_valid), 64'(k == 3));
        end
        chk({tag, "_p"}, 64'(if0.o_p), 64'(exp));
        chk({tag, "_sat"}, 64'(if0.o_sat), 64'd0);
    endtask

    initial begin
        int unsigned nxt;
        int unsigned got;
        bit          held;
        logic [27:0] held_p;

        rst_n = 1'b0;
        clr   = 1'b0;
        if0.i_valid = 1'b0; if0.i_a = '0; if0.i_b = '0; if0.o_ready = 1'b1;
        if1.i_valid = 1'b0; if1.i_a = '0; if1.i_b = '0; if1.o_ready = 1'b1;
        if2.i_valid = 1'b0; if2.i_a = '0; if2.i_b = '0; if2.o_ready = 1'b1;
        if3.i_valid = 1'b0; if3.i_a = '0; if3.i_b = '0; if3.o_ready = 1'b1;
        if4.i_valid = 1'b0; if4.i_a = '0; if4.i_b = '0; if4.o_ready = 1'b1;
        if5.i_valid = 1'b0; if5.i_a = '0; if5.i_b = '0; if5.o_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_valid", 64'(if0.o_valid), 64'd0);
        chk("rst_p", 64'(if0.o_p), 64'd0);
        chk("rst_sat", 64'(if3.o_sat), 64'd0);
        #10 rst_n = 1'b1;
        tick();
        chk("rst_ready", 64'(if0.i_ready), 64'd1);

        // Largest unsigned operands, default parameters
        beat0("t1", 20'hFFFFF, 8'hFF, 28'hFEFFF01);

        // Signed, rounding, saturation and LAT=2 variants side by side
        if1.i_a = 20'hFFFFD; if1.i_b = 8'h05; if1.i_valid = 1'b1;
        if2.i_a = 20'd301;   if2.i_b = 8'd128; if2.i_valid = 1'b1;
        if3.i_a = 20'd1000;  if3.i_b = 8'd100; if3.i_valid = 1'b1;
        if4.i_a = 20'd1000;  if4.i_b = 8'd100; if4.i_valid = 1'b1;
        if5.i_a = 20'd3;     if5.i_b = 8'd4;   if5.i_valid = 1'b1;
        tick();
        if1.i_valid = 1'b0; if3.i_valid = 1'b0; if4.i_valid = 1'b0; if5.i_valid = 1'b0;
        if2.i_a = 20'd300;
        tick();
        chk("lat2_valid", 64'(if5.o_valid), 64'd1);
        chk("lat2_p", 64'(if5.o_p), 64'd12);
        chk("lat3_early", 64'(if1.o_valid), 64'd0);
        if2.i_valid = 1'b0;
        tick();
        chk("lat2_bubble", 64'(if5.o_valid), 64'd0);
        chk("sgn_valid", 64'(if1.o_valid), 64'd1);
        chk("sgn_p", 64'(if1.o_p), 64'h0FFFFFF1);
        chk("sgn_sat", 64'(if1.o_sat), 64'd0);
        chk("rnd_up_valid", 64'(if2.o_valid), 64'd1);
        chk("rnd_up_p", 64'(if2.o_p), 64'd151);
        chk("sat_p", 64'(if3.o_p), 64'hFFFF);
        chk("sat_flag", 64'(if3.o_sat), 64'd1);
        chk("wrap_p", 64'(if4.o_p), 64'h86A0);
        chk("wrap_flag", 64'(if4.o_sat), 64'd0);
        tick();
        chk("rnd_half_valid", 64'(if2.o_valid), 64'd1);
        chk("rnd_half_p", 64'(if2.o_p), 64'd150);
        tick();

        // Backpressure: five beats, output stalled for the first six cycles
        nxt  = 1;
        got  = 0;
        held = 1'b0;
        held_p = '0;
        for (int c = 0; c < 20; c++) begin
            if0.o_ready = (c >= 6);
            if (nxt <= 5) begin
                if0.i_valid = 1'b1;
                if0.i_a     = 20'(nxt);
                if0.i_b     = 8'd2;
            end else begin
                if0.i_valid = 1'b0;
            end
            #1;
            if (c == 2) chk("bp_ready_hi", 64'(if0.i_ready), 64'd1);
            if (c == 3) begin
                chk("bp_ready_lo", 64'(if0.i_ready), 64'd0);
                chk("bp_full", 64'(if0.o_valid), 64'd1);
            end
            if (if0.o_valid && !if0.o_ready) begin
                if (held) chk("bp_stable", 64'(if0.o_p), 64'(held_p));
                held   = 1'b1;
                held_p = if0.o_p;
            end else begin
                held = 1'b0;
            end
            if (if0.o_valid && if0.o_ready) begin
                chk("bp_out", 64'(if0.o_p), 64'(2 * (got + 1)));
                got++;
            end
            if (if0.i_valid && if0.i_ready) nxt++;
            tick();
        end
        chk("bp_count", 64'(got), 64'd5);
        chk("bp_drained", 64'(if0.o_valid), 64'd0);

        // Synchronous clear with three beats in flight
        if0.o_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            if0.i_a = 20'(k); if0.i_b = 8'd1; if0.i_valid = 1'b1;
            tick();
        end
        clr = 1'b1;
        if0.i_a = 20'd9;
        #1;
        chk("clr_ready", 64'(if0.i_ready), 64'd0);
        tick();
        clr = 1'b0;
        if0.i_valid = 1'b0;
        chk("clr_valid", 64'(if0.o_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("clr_empty", 64'(if0.o_valid), 64'd0);
        end
        beat0("clr_new", 20'd7, 8'd3, 28'd21);
        tick();

        // Asynchronous reset with three beats in flight
        for (int k = 1; k <= 3; k++) begin
            if0.i_a = 20'(k + 4); if0.i_b = 8'd1; if0.i_valid = 1'b1;
            tick();
        end
        if0.i_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(if0.o_valid), 64'd0);
        chk("arst_p", 64'(if0.o_p), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("arst_empty", 64'(if0.o_valid), 64'd0);
        end
        beat0("arst_new", 20'd7, 8'd3, 28'd21);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
